// File: rtl/vga_bram_scheduler_pkg.sv
// Shared VGA timing constants and frame-buffer sizing for the BRAM scheduler.
package vga_bram_scheduler_pkg;

  localparam int unsigned H_ACT   = 640;
  localparam int unsigned V_ACT   = 480;
  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned P_WIDTH = 96;
  localparam int unsigned FB_SIZE = H_ACT * V_ACT;
  localparam int unsigned FB_AW   = 19;

  typedef enum logic {
    ST_IDLE,
    ST_GAP
  } host_state_t;

endpackage

// File: rtl/vga_bram_scheduler.sv
// Single-port frame-buffer arbiter: raster fetch always wins, host gets one
// access per two cycles during blanking, with a sticky starvation flag.
module vga_bram_scheduler
  import vga_bram_scheduler_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = FB_AW,
  parameter int unsigned STARVE_LIM = 1024,
  parameter int unsigned FB_DEPTH   = FB_SIZE
) (
  input  logic              VGA_CLK,
  input  logic              RST_N,
  input  logic              valid,
  input  logic              VGA_VS,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              starve_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

  host_state_t       state, next_state;
  logic [ADDR_W-1:0] vaddr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              raster_tag;
  logic              host_rd_tag;
  logic              raster_go;
  logic              grant;

  // The port mux is gated by reset so a held request cannot leak through
  // while the block is being reset.
  assign raster_go = RST_N & valid;
  assign grant     = RST_N & ~valid & host_req & (state == ST_IDLE);

  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = '0;
    bram_din   = '0;
    host_ack   = 1'b0;
    next_state = state;
    if (raster_go) begin
      bram_en   = 1'b1;
      bram_addr = vaddr;
    end else if (grant) begin
      bram_en   = 1'b1;
      bram_we   = host_we;
      bram_addr = host_addr;
      bram_din  = host_wdata;
      host_ack  = 1'b1;
    end
    case (state)
      ST_IDLE: if (grant) next_state = ST_GAP;
      ST_GAP:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      vaddr <= '0;
    end else if (!VGA_VS) begin
      vaddr <= '0;
    end else if (valid) begin
      if (vaddr == ADDR_W'(FB_DEPTH - 1)) vaddr <= '0;
      else                                vaddr <= vaddr + 1'b1;
    end
  end

  // Each pipe carries a 1-bit tag for the cycle it issued, so a host read
  // and a raster read in adjacent cycles each pick up their own BRAM word.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      raster_tag  <= 1'b0;
      host_rd_tag <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      raster_tag  <= raster_go;
      host_rd_tag <= host_ack & ~host_we;
      pix_valid   <= raster_tag;
      pix_data    <= raster_tag ? bram_dout : '0;
      host_rvalid <= host_rd_tag;
      if (host_rd_tag) host_rdata <= bram_dout;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt   <= '0;
      starve_err <= 1'b0;
    end else begin
      if (!host_req || host_ack)               wait_cnt <= '0;
      else if (wait_cnt != CNT_W'(STARVE_LIM)) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == CNT_W'(STARVE_LIM))      starve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_bram_scheduler.sv
// Directed bench for vga_bram_scheduler with a behavioural 1-cycle BRAM.
module tb_vga_bram_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, vs, host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack, host_rvalid, bram_en, bram_we, pix_valid, starve_err;
  logic [DW-1:0] host_rdata, bram_din, bram_dout, pix_data;
  logic [AW-1:0] bram_addr;

  logic          s_ack, s_rvalid, s_en, s_we, s_pix_valid, s_starve;
  logic [DW-1:0] s_rdata, s_din, s_pix_data;
  logic [AW-1:0] s_addr;

  logic [DW-1:0] mem [256];
  logic          load;
  int            wr_cnt, ack_cnt;
  int            n_checks, n_pass, n_fail;
  int            seen, a0, w0;

  always #5 clk = ~clk;

  vga_bram_scheduler #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(1024), .FB_DEPTH(16)) dut (
    .VGA_CLK(clk), .RST_N(rst_n), .valid(valid), .VGA_VS(vs),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .pix_valid(pix_valid), .pix_data(pix_data), .starve_err(starve_err)
  );

  vga_bram_scheduler #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(16), .FB_DEPTH(16)) dut_s (
    .VGA_CLK(clk), .RST_N(rst_n), .valid(valid), .VGA_VS(vs),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(s_ack), .host_rdata(s_rdata), .host_rvalid(s_rvalid),
    .bram_en(s_en), .bram_we(s_we), .bram_addr(s_addr), .bram_din(s_din),
    .bram_dout(bram_dout), .pix_valid(s_pix_valid), .pix_data(s_pix_data), .starve_err(s_starve)
  );

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
    end else if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_din;
        wr_cnt <= wr_cnt + 1;
      end
      bram_dout <= mem[bram_addr];
    end
    if (host_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    wr_cnt = 0; ack_cnt = 0; bram_dout = '0;
    rst_n = 1'b0; load = 1'b1; valid = 1'b0; vs = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    cyc(); cyc();
    load = 1'b0;

    // Reset mid-frame with a pending host write
    rst_n = 1'b1; valid = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h80; host_wdata = 8'h11;
    #1 chk("ack_while_valid", host_ack, 0);
    chk("raster_en", bram_en, 1);
    cyc(); cyc(); cyc();
    chk("pix_before_reset", pix_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ack", host_ack, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_starve", starve_err, 0);
    valid = 1'b0;
    cyc();
    chk("rst_held_ack", host_ack, 0);
    rst_n = 1'b1; valid = 1'b1;
    #1 chk("post_rst_valid_ack", host_ack, 0);
    cyc();
    valid = 1'b0;
    #1 chk("post_rst_ack", host_ack, 1);
    chk("post_rst_addr", bram_addr, 8'h80);
    chk("post_rst_we", bram_we, 1);
    cyc();
    chk("gap_no_ack", host_ack, 0);
    host_req = 1'b0;
    cyc();

    // Raster frame: addresses wrap at 16, pixels trail by 2 cycles
    vs = 1'b0; cyc();
    vs = 1'b1; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("raster_addr", bram_addr, k % 16);
      chk("pix_valid_run", pix_valid, (k >= 2) ? 1 : 0);
      chk("pix_data_run", pix_data, (k >= 2) ? ((k - 2) % 16) : 0);
      cyc();
    end
    valid = 1'b0;
    chk("pix_tail0", pix_data, 18 % 16);
    cyc();
    chk("pix_tail1", pix_data, 19 % 16);
    cyc();
    chk("pix_off_valid", pix_valid, 0);
    chk("pix_off_data", pix_data, 0);
    vs = 1'b0; cyc();
    vs = 1'b1; valid = 1'b1;
    #1 chk("vs_restart_addr", bram_addr, 0);
    cyc(); cyc();
    chk("vs_restart_pix", pix_valid, 1);
    chk("vs_restart_data", pix_data, 0);
    cyc();
    chk("vs_restart_data1", pix_data, 1);
    valid = 1'b0;
    cyc(); cyc(); cyc();

    // Host write 0xA5 to addr 5, then read it back
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd5; host_wdata = 8'hA5;
    #1 chk("wr_ack", host_ack, 1);
    cyc();
    host_we = 1'b0;
    #1 chk("rd_gap_ack", host_ack, 0);
    cyc();
    chk("rd_ack", host_ack, 1);
    chk("rd_we", bram_we, 0);
    cyc();
    host_req = 1'b0;
    chk("rd_rvalid_t1", host_rvalid, 0);
    cyc();
    chk("rd_rvalid_t2", host_rvalid, 1);
    chk("rd_rdata", host_rdata, 8'hA5);
    cyc();
    chk("rd_rvalid_t3", host_rvalid, 0);
    chk("rd_rdata_hold", host_rdata, 8'hA5);

    // Request held one extra cycle after ack: one ack, one write
    a0 = ack_cnt; w0 = wr_cnt;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd7; host_wdata = 8'h3C;
    cyc(); cyc();
    host_req = 1'b0;
    cyc(); cyc();
    chk("held_ack_count", ack_cnt - a0, 1);
    chk("held_write_count", wr_cnt - w0, 1);

    // Host read acked in the last blanking cycle, raster starts next cycle
    vs = 1'b0; cyc();
    vs = 1'b1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd7;
    #1 chk("edge_rd_ack", host_ack, 1);
    cyc();
    host_req = 1'b0; valid = 1'b1;
    cyc();
    chk("edge_rvalid", host_rvalid, 1);
    chk("edge_rdata", host_rdata, 8'h3C);
    chk("edge_pix_not_yet", pix_valid, 0);
    cyc();
    chk("edge_pix_valid", pix_valid, 1);
    chk("edge_pix_data", pix_data, 0);
    valid = 1'b0;
    cyc();
    chk("edge_pix_data1", pix_data, 1);
    cyc(); cyc();

    // Starvation with limit 16
    valid = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
    for (int k = 0; k < 15; k++) cyc();
    chk("starve_before_lim", s_starve, 0);
    cyc(); cyc();
    chk("starve_set", s_starve, 1);
    cyc(); cyc(); cyc();
    valid = 1'b0;
    #1 chk("starve_late_ack", host_ack, 1);
    cyc();
    host_req = 1'b0;
    cyc();
    chk("starve_sticky", s_starve, 1);
    chk("starve_main_clear", starve_err, 0);

    // 640-cycle conflict: no ack until valid drops, limit 1024 not reached
    valid = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
    seen = 0;
    for (int k = 0; k < 640; k++) begin
      #1 if (host_ack) seen++;
      cyc();
    end
    chk("conflict_no_ack", seen, 0);
    valid = 1'b0;
    #1 chk("conflict_ack", host_ack, 1);
    chk("conflict_starve", starve_err, 0);
    cyc();
    host_req = 1'b0;
    cyc();
    chk("conflict_rvalid", host_rvalid, 1);
    chk("conflict_rdata", host_rdata, 8'hA5);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_bram_scheduler.md
# vga_bram_scheduler

Owns the single BRAM port of the frame buffer and shares it between the raster pixel fetch and a host (AXI-slave-side) requester. Raster fetch has absolute priority: whenever `valid` from `vga_sync_module` is high, the port reads the next pixel. The host is served one access at a time during blanking through a req/ack handshake. Sits between `vga_sync_module`, the frame-buffer BRAM and the host register interface.

## Interface
- `DATA_W`, 8: pixel/host data width
- `ADDR_W`, `FB_AW` (19): BRAM address width
- `STARVE_LIM`, 1024: host wait cycles before `starve_err` sets

- `VGA_CLK` in 1: sole clock
- `RST_N` in 1: reset, asynchronous, active-low
- `valid` in 1: active-pixel strobe from `vga_sync_module`
- `VGA_VS` in 1: vertical sync, low during sync
- `host_req` in 1: host access request, held until ack
- `host_we` in 1: 1 = write, 0 = read
- `host_addr` in ADDR_W: host BRAM address
- `host_wdata` in DATA_W: host write data
- `host_ack` out 1: one-cycle pulse, access performed this cycle
- `host_rdata` out DATA_W: read data, held until next read
- `host_rvalid` out 1: one-cycle pulse, `host_rdata` updated
- `bram_en`, `bram_we` out 1: port enable / write enable
- `bram_addr` out ADDR_W, `bram_din` out DATA_W: port address / write data
- `bram_dout` in DATA_W: port read data, 1-cycle synchronous latency
- `pix_valid` out 1, `pix_data` out DATA_W: pixel stream to DAC/output stage
- `starve_err` out 1: sticky host-starvation flag

## Operation
- Reset: all registered outputs are 0. `vaddr`=0, FSM=IDLE, `wait_cnt`=0. An in-flight host access is dropped, with no ack or rvalid. The host re-requests after reset.
- Raster address `vaddr`:
  - Cleared while `VGA_VS`=0.
  - Otherwise increments after every `valid` cycle.
  - Wraps from `FB_SIZE-1` to 0.
- Port mux, combinational, in priority order:
  - `valid`=1: `bram_en`=1, `bram_we`=0, `bram_addr`=`vaddr`.
  - Else FSM=IDLE and `host_req`=1: `bram_en`=1, `bram_we`=`host_we`, `bram_addr`=`host_addr`, `bram_din`=`host_wdata`, `host_ack`=1.
  - Else: `bram_en`=0, `bram_we`=0, `bram_addr`/`bram_din` = 0.
- FSM:
  - IDLE → GAP on any `host_ack`.
  - GAP → IDLE unconditionally. No grant occurs in GAP, so a held `host_req` is never served twice.
  - Host must drop `host_req` or present a new request in the cycle after ack.
- Priority conflict: `valid` and `host_req` high in the same cycle → raster wins, no ack. The host request stays pending.
- Starvation:
  - `wait_cnt` increments each cycle `host_req`=1 without ack. It clears on ack or when `host_req`=0, and saturates.
  - `starve_err` sets when `wait_cnt`=`STARVE_LIM` and stays set until reset.
- Arithmetic: `vaddr` is unsigned `FB_AW` bits. Wrap is by compare, not overflow.

## Timing
- Raster: `valid` high in cycle t → `bram_dout` valid in t+1, registered → `pix_valid`=1 and `pix_data` in t+2.
  - `pix_data`=0 whenever `pix_valid`=0.
  - Latency is a fixed 2 cycles.
- Host write: ack in cycle t; BRAM written at the end of t.
- Host read: ack in cycle t → `host_rvalid` pulse and `host_rdata` in t+2.
  - `host_rdata` holds its value otherwise.
- Back-to-back host accesses: at most one per 2 cycles (ack, GAP).
- `valid` rising while FSM=GAP has no effect on the raster path; the raster owns the port.
- A host read acked in the last blanking cycle is followed by `valid` at t+1. Both pipelines run concurrently with no collision, because each tags its own cycle.

## Structure
- Shared constants go in `vga_params.v`:
  - Existing: `H_ACT`, `V_ACT`, `H_TOTAL`, `P_WIDTH`.
  - Add `FB_SIZE` (`H_ACT`*`V_ACT`) and `FB_AW` (19).
- Single flat module, no sub-module.
- The raster read pipe and host read pipe are two 1-bit tag shift registers plus data registers inside this module.

## Test plan
- Reset mid-frame with `host_req`=1 → all outputs 0. After release, `host_ack` occurs in the first non-`valid` cycle.
- Host write 0xA5 to addr 5 during blanking, then read addr 5 → ack pulses 2 cycles apart; `host_rvalid` 2 cycles after the read ack with `host_rdata`=0xA5.
- `host_req` and `valid` rise together, `valid` high 640 cycles → no ack for 640 cycles; ack in the first cycle `valid`=0; `starve_err` stays 0.
- Full frame, BRAM preloaded with data = addr[7:0] → `pix_valid` trails `valid` by 2 cycles. `pix_data` is 0,1,2… and restarts at 0 after `VGA_VS` low.
- `host_req` held high for 2 cycles after ack → exactly one ack, one BRAM write.
- `STARVE_LIM`=16, `valid` forced high for 20 cycles with `host_req`=1 → `starve_err` sets at cycle 16 and remains set after the ack.
